// File: rtl/sdio_cmd_resp_tx_pkg.sv
// ============================================================================
//  Module      : sdio_pkg
//  Description : Shared constants for the SD CMD-line blocks: CRC7 polynomial,
//                frame geometry and the one-hot response FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdio_pkg;

    // x^7 + x^3 + 1 with the x^7 term implied by the shift
    localparam logic [6:0] CRC7_POLY      = 7'h09;
    localparam int         CMD_FRAME_BITS = 48;

    // Payload is the frame minus CRC7 and the end bit
    localparam int         c_payload_bits = CMD_FRAME_BITS - 8;
    localparam logic [5:0] c_payload_last = 6'(c_payload_bits - 1);
    localparam logic [5:0] c_crc_last     = 6'd6;

    // One-hot FSM encoding
    localparam logic [4:0] c_st_idle  = 5'b00001;
    localparam logic [4:0] c_st_ncr   = 5'b00010;
    localparam logic [4:0] c_st_shift = 5'b00100;
    localparam logic [4:0] c_st_crc   = 5'b01000;
    localparam logic [4:0] c_st_end   = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/sdio_cmd_resp_tx_if.sv
// ============================================================================
//  Module      : sdio_cmd_resp_tx_if
//  Description : Request handshake and CMD-line outputs of the response
//                transmitter. The master side presents requests, the slave
//                side (the transmitter) drives the line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdio_cmd_resp_tx_if;
    logic        resp_valid;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        resp_ready;
    logic        cmd_o;
    logic        cmd_oe;
    logic        busy;
    logic        done;

    modport master (
        output resp_valid, resp_index, resp_arg,
        input  resp_ready, cmd_o, cmd_oe, busy, done
    );

    modport slave (
        input  resp_valid, resp_index, resp_arg,
        output resp_ready, cmd_o, cmd_oe, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/sdio_cmd_resp_tx_sd_crc7.sv
// ============================================================================
//  Module      : sd_crc7
//  Description : Serial CRC7 (x^7+x^3+1, init 0), one bit per enabled clock,
//                MSB-first register. Shared by the CMD transmitter and the
//                host-to-card receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd_crc7
    import sdio_pkg::*;
(
    input  wire logic       sd_clk,
    input  wire logic       clear,
    input  wire logic       enable,
    input  wire logic       bit_in,
    output logic      [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb = bit_in ^ r_crc[6];

    // Clear has priority so a new frame can start on the same edge it is accepted
    always_ff @(posedge sd_clk) begin
        if (clear) begin
            r_crc <= 7'h00;
        end else if (enable) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/sdio_cmd_resp_tx.sv
// ============================================================================
//  Module      : sdio_cmd_resp_tx
//  Description : SD card response transmitter. Accepts one response request,
//                drives NCR idle-high bits, then the 48-bit frame (start,
//                direction, index, arg, CRC7, end) MSB first on CMD.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdio_cmd_resp_tx
    import sdio_pkg::*;
#(
    parameter int NCR_CYCLES = 2
) (
    input  wire logic           sd_clk,
    input  wire logic           rst,
    sdio_cmd_resp_tx_if.slave   bus
);

    localparam logic [5:0] c_ncr_last = 6'(NCR_CYCLES - 1);

    logic [4:0]  r_state;
    logic [5:0]  r_cnt;
    logic [39:0] r_shift;
    logic        r_done;
    logic        w_accept;
    logic        w_crc_clear;
    logic        w_crc_en;
    logic [6:0]  w_crc;
    logic [2:0]  w_crc_idx;
    logic        w_cmd;

    assign bus.resp_ready = (r_state == c_st_idle) && !rst;
    assign w_accept       = bus.resp_valid && bus.resp_ready;

    // CRC restarts from zero on every accepted frame and on reset
    assign w_crc_clear = rst || w_accept;
    assign w_crc_en    = (r_state == c_st_shift);

    sd_crc7 u_crc7 (
        .sd_clk (sd_clk),
        .clear  (w_crc_clear),
        .enable (w_crc_en),
        .bit_in (r_shift[39]),
        .crc    (w_crc)
    );

    // Frame sequencer: each state counts its own bits from zero and exits on an exact match
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 6'd0;
            r_shift <= 40'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state <= c_st_ncr;
                        r_cnt   <= 6'd0;
                        r_shift <= {2'b00, bus.resp_index, bus.resp_arg};
                    end
                end
                c_st_ncr: begin
                    if (r_cnt == c_ncr_last) begin
                        r_state <= c_st_shift;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_st_shift: begin
                    r_shift <= {r_shift[38:0], 1'b0};
                    if (r_cnt == c_payload_last) begin
                        r_state <= c_st_crc;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_st_crc: begin
                    if (r_cnt == c_crc_last) begin
                        r_state <= c_st_end;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                c_st_end: begin
                    r_state <= c_st_idle;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

    // CRC is held during its own phase, so it is read out MSB first by index
    assign w_crc_idx = 3'd6 - r_cnt[2:0];

    // Line data: idle/NCR/end bits are high, payload and CRC come from their registers
    always_comb begin
        w_cmd = 1'b1;
        case (r_state)
            c_st_shift: w_cmd = r_shift[39];
            c_st_crc:   w_cmd = w_crc[w_crc_idx];
            default:    w_cmd = 1'b1;
        endcase
    end

    assign bus.cmd_o  = w_cmd;
    assign bus.cmd_oe = (r_state != c_st_idle);
    assign bus.busy   = (r_state != c_st_idle);
    assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sdio_cmd_resp_tx.sv
// ============================================================================
//  Module      : tb_sdio_cmd_resp_tx
//  Description : Directed self-checking bench for the SD response transmitter
//                and its CRC7 sub-block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdio_cmd_resp_tx;

    logic sd_clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 sd_clk = ~sd_clk;

    sdio_cmd_resp_tx_if bus_a ();
    sdio_cmd_resp_tx_if bus_b ();

    sdio_cmd_resp_tx #(.NCR_CYCLES(2)) u_dut_a (
        .sd_clk (sd_clk),
        .rst    (rst),
        .bus    (bus_a.slave)
    );

    sdio_cmd_resp_tx #(.NCR_CYCLES(64)) u_dut_b (
        .sd_clk (sd_clk),
        .rst    (rst),
        .bus    (bus_b.slave)
    );

    logic       crc_clear;
    logic       crc_en;
    logic       crc_bit;
    logic [6:0] crc_out;

    sd_crc7 u_crc (
        .sd_clk (sd_clk),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_out)
    );

    localparam logic [47:0] c_r7_frame = 48'h08_0000_01AA_13;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame by polynomial long division of M(x)*x^7 by 0x89
    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] msg;
        logic [46:0] rem;
        msg = {2'b00, idx, arg};
        rem = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        end
        return {msg, rem[6:0], 1'b1};
    endfunction

    task automatic crc_feed(input logic [39:0] vec);
        @(negedge sd_clk);
        crc_clear = 1'b1;
        @(posedge sd_clk); #1;
        crc_clear = 1'b0;
        crc_en    = 1'b1;
        for (int i = 39; i >= 0; i--) begin
            crc_bit = vec[i];
            @(posedge sd_clk); #1;
        end
        crc_en = 1'b0;
    endtask

    // Presents a request on DUT A and returns just after the accepting edge
    task automatic request(input logic [5:0] idx, input logic [31:0] arg);
        @(negedge sd_clk);
        bus_a.resp_valid = 1'b1;
        bus_a.resp_index = idx;
        bus_a.resp_arg   = arg;
        check_eq("ready_at_request", bus_a.resp_ready, 1);
        @(posedge sd_clk); #1;
        bus_a.resp_valid = 1'b0;
    endtask

    // Called just after the accepting edge; ends at the negedge of the done cycle
    task automatic expect_frame(input string tag, input logic [47:0] exp);
        logic [47:0] got;
        int          ncr_ok = 1;
        int          oe_ok  = 1;
        got = 48'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge sd_clk);
            if (!(bus_a.cmd_oe && bus_a.cmd_o && bus_a.busy && !bus_a.resp_ready)) ncr_ok = 0;
        end
        for (int i = 0; i < 48; i++) begin
            @(negedge sd_clk);
            got = {got[46:0], bus_a.cmd_o};
            if (!bus_a.cmd_oe || !bus_a.busy || bus_a.done || bus_a.resp_ready) oe_ok = 0;
        end
        check_eq({tag, "_ncr"}, ncr_ok, 1);
        check_eq({tag, "_frame"}, got, exp);
        check_eq({tag, "_oe_busy"}, oe_ok, 1);
        @(negedge sd_clk);
        check_eq({tag, "_done_cycle"},
                 {bus_a.done, bus_a.cmd_oe, bus_a.busy, bus_a.resp_ready, bus_a.cmd_o}, 5'b10011);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] got_b;
        int          highs;
        int          cnt;

        rst = 1'b1;
        bus_a.resp_valid = 1'b0; bus_a.resp_index = 6'd0; bus_a.resp_arg = 32'd0;
        bus_b.resp_valid = 1'b0; bus_b.resp_index = 6'd0; bus_b.resp_arg = 32'd0;
        crc_clear = 1'b1; crc_en = 1'b0; crc_bit = 1'b0;

        // Reset state
        repeat (3) @(posedge sd_clk);
        @(negedge sd_clk);
        check_eq("reset_outputs",
                 {bus_a.resp_ready, bus_a.cmd_oe, bus_a.cmd_o, bus_a.busy, bus_a.done}, 5'b00100);
        rst = 1'b0;
        @(posedge sd_clk);
        @(negedge sd_clk);
        check_eq("ready_after_reset", bus_a.resp_ready, 1);
        check_eq("idle_line", {bus_a.cmd_oe, bus_a.cmd_o}, 2'b01);

        // CRC7 sub-block
        crc_feed(40'h40_0000_0000);
        check_eq("crc_cmd0", crc_out, 7'h4A);
        crc_feed(40'h08_0000_01AA);
        check_eq("crc_r7", crc_out, 7'h09);

        // Basic R7 frame: start bit at T+3, done at T+51
        request(6'd8, 32'h0000_01AA);
        expect_frame("r7", c_r7_frame);
        @(negedge sd_clk);
        check_eq("done_single_pulse", bus_a.done, 0);

        // Back-to-back: valid held through done, second frame starts without gap
        @(negedge sd_clk);
        bus_a.resp_valid = 1'b1;
        bus_a.resp_index = 6'd8;
        bus_a.resp_arg   = 32'h0000_01AA;
        @(posedge sd_clk); #1;
        fork
            expect_frame("b2b_first", c_r7_frame);
            begin
                @(posedge sd_clk); #1;
                bus_a.resp_index = 6'h11;
                bus_a.resp_arg   = 32'hDEAD_BEEF;
            end
        join
        @(posedge sd_clk); #1;
        bus_a.resp_valid = 1'b0;
        expect_frame("b2b_second", ref_frame(6'h11, 32'hDEAD_BEEF));

        // Requests and input changes while busy are ignored
        request(6'd8, 32'h0000_01AA);
        fork
            expect_frame("busy_ignore", c_r7_frame);
            begin
                repeat (5) @(posedge sd_clk); #1;
                bus_a.resp_valid = 1'b1;
                bus_a.resp_index = 6'h3F;
                bus_a.resp_arg   = 32'hFFFF_FFFF;
                repeat (3) @(posedge sd_clk); #1;
                bus_a.resp_valid = 1'b0;
                repeat (20) @(posedge sd_clk); #1;
                bus_a.resp_index = 6'h15;
                bus_a.resp_arg   = 32'h1234_5678;
            end
        join
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sd_clk);
            if (bus_a.cmd_oe || bus_a.done) cnt++;
        end
        check_eq("no_second_frame", cnt, 0);

        // Reset mid-frame during frame bit 19 (arg bit 20)
        request(6'h2A, 32'h0F0F_0F0F);
        repeat (21) @(posedge sd_clk); #1;
        rst = 1'b1;
        @(posedge sd_clk); #1;
        rst = 1'b0;
        @(negedge sd_clk);
        check_eq("abort_outputs", {bus_a.cmd_oe, bus_a.cmd_o, bus_a.done, bus_a.busy}, 4'b0100);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sd_clk);
            if (bus_a.cmd_oe || bus_a.done) cnt++;
        end
        check_eq("abort_no_done", cnt, 0);
        request(6'h2A, 32'h0F0F_0F0F);
        expect_frame("after_abort", ref_frame(6'h2A, 32'h0F0F_0F0F));

        // NCR_CYCLES=64 instance
        @(negedge sd_clk);
        bus_b.resp_valid = 1'b1;
        bus_b.resp_index = 6'd8;
        bus_b.resp_arg   = 32'h0000_01AA;
        @(posedge sd_clk); #1;
        bus_b.resp_valid = 1'b0;
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sd_clk);
            if (bus_b.cmd_oe && bus_b.cmd_o) highs++;
            else break;
        end
        check_eq("ncr64_high_bits", highs, 64);
        check_eq("ncr64_start_oe", bus_b.cmd_oe, 1);
        got_b = {47'd0, bus_b.cmd_o};
        for (int i = 0; i < 47; i++) begin
            @(negedge sd_clk);
            got_b = {got_b[46:0], bus_b.cmd_o};
        end
        check_eq("ncr64_frame", got_b, c_r7_frame);
        @(negedge sd_clk);
        check_eq("ncr64_done", {bus_b.done, bus_b.cmd_oe}, 2'b10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
